// File: rtl/sls_updown_modcnt.sv
// Up/down modulo counter with parallel load, count enable and wrap/saturate limit handling.
// Wrap is a registered pulse; TC is combinational from Q and Up for cascading.
module sls_updown_modcnt #(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MODULUS   = 256,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] D,
    input  logic             LD_EN,
    input  logic             Cnt_EN,
    input  logic             Up,
    input  logic             Sat_Mode,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap
);

    // MODULUS may be 2^WIDTH, so the limit is formed from MODULUS-1 to stay within WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_val;
    logic             wrap_reg;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;

    always_comb begin
        at_max     = (count_reg == MAX_VAL);
        at_zero    = (count_reg == '0);
        load_val   = (D > MAX_VAL) ? MAX_VAL : D;
        count_next = count_reg;
        wrap_next  = 1'b0;

        if (LD_EN) begin
            count_next = load_val;
        end else if (Cnt_EN) begin
            if (Up) begin
                if (!at_max) begin
                    count_next = count_reg + WIDTH'(1);
                end else if (!Sat_Mode) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_next = count_reg - WIDTH'(1);
                end else if (!Sat_Mode) begin
                    count_next = MAX_VAL;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            count_reg <= RST_VAL;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign Q    = count_reg;
    assign Wrap = wrap_reg;
    assign TC   = Up ? at_max : at_zero;

endmodule

// File: tb/tb_sls_updown_modcnt.sv
// Bench for sls_updown_modcnt: three configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model, plus directed checks.
module tb_sls_updown_modcnt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d = '0;
    logic       ld = 1'b0;
    logic       cnt = 1'b0;
    logic       up = 1'b1;
    logic       sat = 1'b0;

    logic [7:0] qa;
    logic [3:0] qb;
    logic [0:0] qc;
    logic       tca, tcb, tcc;
    logic       wrapa, wrapb, wrapc;

    int n_checks = 0;
    int n_pass   = 0;

    longint unsigned mod_v[3] = '{256, 10, 2};
    longint unsigned rv_v[3]  = '{0, 3, 1};
    int unsigned     wid_v[3] = '{8, 4, 1};
    longint unsigned mq[3]    = '{0, 0, 0};
    longint unsigned mw[3]    = '{0, 0, 0};

    always #5 clk = ~clk;

    sls_updown_modcnt #(.WIDTH(8), .MODULUS(256), .RESET_VAL(0)) dut_a (
        .Clock(clk), .Reset_n(rst_n), .D(d), .LD_EN(ld), .Cnt_EN(cnt), .Up(up),
        .Sat_Mode(sat), .Q(qa), .TC(tca), .Wrap(wrapa)
    );

    sls_updown_modcnt #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut_b (
        .Clock(clk), .Reset_n(rst_n), .D(d[3:0]), .LD_EN(ld), .Cnt_EN(cnt), .Up(up),
        .Sat_Mode(sat), .Q(qb), .TC(tcb), .Wrap(wrapb)
    );

    sls_updown_modcnt #(.WIDTH(1), .MODULUS(2), .RESET_VAL(1)) dut_c (
        .Clock(clk), .Reset_n(rst_n), .D(d[0:0]), .LD_EN(ld), .Cnt_EN(cnt), .Up(up),
        .Sat_Mode(sat), .Q(qc), .TC(tcc), .Wrap(wrapc)
    );

    task automatic check(input string tag, input longint unsigned got,
                         input longint unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic longint unsigned get_q(input int i);
        case (i)
            0:       return longint'(qa);
            1:       return longint'(qb);
            default: return longint'(qc);
        endcase
    endfunction

    function automatic logic get_tc(input int i);
        case (i)
            0:       return tca;
            1:       return tcb;
            default: return tcc;
        endcase
    endfunction

    function automatic logic get_wrap(input int i);
        case (i)
            0:       return wrapa;
            1:       return wrapb;
            default: return wrapc;
        endcase
    endfunction

    // Reference behaviour straight from the counting rules, using modular arithmetic.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            longint unsigned dv;
            longint unsigned lim;
            logic            at_limit;
            dv       = longint'(d) % (64'd1 << wid_v[i]);
            lim      = up ? mod_v[i] - 1 : 0;
            at_limit = (mq[i] == lim);
            if (!rst_n) begin
                mq[i] = rv_v[i];
                mw[i] = 0;
            end else if (ld) begin
                mq[i] = (dv < mod_v[i]) ? dv : mod_v[i] - 1;
                mw[i] = 0;
            end else if (cnt) begin
                if (sat && at_limit) begin
                    mw[i] = 0;
                end else begin
                    mw[i] = at_limit ? 1 : 0;
                    mq[i] = up ? (mq[i] + 1) % mod_v[i] : (mq[i] + mod_v[i] - 1) % mod_v[i];
                end
            end else begin
                mw[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            longint unsigned exp_tc;
            exp_tc = up ? ((mq[i] == mod_v[i] - 1) ? 1 : 0) : ((mq[i] == 0) ? 1 : 0);
            check($sformatf("%s_q%0d", tag, i), get_q(i), mq[i]);
            check($sformatf("%s_wrap%0d", tag, i), longint'(get_wrap(i)), mw[i]);
            check($sformatf("%s_tc%0d", tag, i), longint'(get_tc(i)), exp_tc);
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset
        rst_n = 1'b0; ld = 1'b1; cnt = 1'b1; d = 8'd200;
        tick("reset");
        check("reset_qa", longint'(qa), 0);
        check("reset_qb", longint'(qb), 3);
        check("reset_wrapb", longint'(wrapb), 0);

        // Full up-count of the default configuration
        rst_n = 1'b1; ld = 1'b0; cnt = 1'b1; up = 1'b1; sat = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            tick("upcnt");
            check("upcnt_qa", longint'(qa), longint'(k % 256));
            check("upcnt_wrapa", longint'(wrapa), (k == 256) ? 1 : 0);
            check("upcnt_tca", longint'(tca), (k == 255) ? 1 : 0);
        end

        // Clamped load then wrap
        ld = 1'b1; d = 8'd12;
        tick("clamp");
        check("clamp_qb", longint'(qb), 9);
        check("clamp_tcb", longint'(tcb), 1);
        ld = 1'b0; cnt = 1'b1; up = 1'b1; sat = 1'b0;
        tick("upwrap");
        check("upwrap_qb", longint'(qb), 0);
        check("upwrap_wrapb", longint'(wrapb), 1);

        // Saturate up then down to zero
        ld = 1'b1; d = 8'd8;
        tick("ld8");
        ld = 1'b0; sat = 1'b1; up = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick("satup");
            check("satup_qb", longint'(qb), 9);
            check("satup_wrapb", longint'(wrapb), 0);
        end
        up = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick("satdn");
            check("satdn_qb", longint'(qb), (k < 9) ? longint'(8 - k) : 0);
            check("satdn_wrapb", longint'(wrapb), 0);
        end

        // Down wrap
        ld = 1'b1; d = 8'd1;
        tick("ld1");
        ld = 1'b0; up = 1'b0; sat = 1'b0;
        tick("dn0");
        check("dn0_qb", longint'(qb), 0);
        check("dn0_tcb", longint'(tcb), 1);
        tick("dnwrap");
        check("dnwrap_qb", longint'(qb), 9);
        check("dnwrap_wrapb", longint'(wrapb), 1);

        // Priority: reset over load over count
        rst_n = 1'b0; ld = 1'b1; cnt = 1'b1; d = 8'd5;
        tick("prio_rst");
        check("prio_rst_qb", longint'(qb), 3);
        rst_n = 1'b1;
        tick("prio_ld");
        check("prio_ld_qb", longint'(qb), 5);

        // Reset mid-count
        ld = 1'b0; cnt = 1'b1; up = 1'b1; sat = 1'b0;
        tick("mid1");
        tick("mid2");
        check("mid_qb", longint'(qb), 7);
        rst_n = 1'b0;
        tick("midrst");
        check("midrst_qb", longint'(qb), 3);
        check("midrst_wrapb", longint'(wrapb), 0);
        rst_n = 1'b1;
        tick("resume");
        check("resume_qb", longint'(qb), 4);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            ld    = ($urandom_range(0, 9) == 0);
            cnt   = ($urandom_range(0, 9) < 7);
            up    = 1'($urandom_range(0, 1));
            sat   = 1'($urandom_range(0, 3) == 0);
            d     = 8'($urandom);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sls_updown_modcnt.md
# sls_updown_modcnt

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and selectable wrap or saturate behaviour at the count limits. It is the general-purpose successor to the team's fixed 8-bit load/enable up counter, for use as a sequencer address counter, timer and BCD-style digit stage. Cascading uses the `TC` and `Wrap` outputs.

## Interface
- `WIDTH`, default 8: counter width in bits; legal range 1..32.
- `MODULUS`, default 256: count range is 0..`MODULUS`-1; legal range 2..2^`WIDTH`.
- `RESET_VAL`, default 0: value loaded on reset; must be less than `MODULUS`.
- `Clock`  in  1  sole clock; all state updates on its rising edge.
- `Reset_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `Clock`.
- `D`  in  `WIDTH`  parallel load value.
- `LD_EN`  in  1  load enable, active high.
- `Cnt_EN`  in  1  count enable, active high.
- `Up`  in  1  direction: 1 counts up, 0 counts down.
- `Sat_Mode`  in  1  limit mode: 1 saturates at the limit, 0 wraps around.
- `Q`  out  `WIDTH`  registered count value.
- `TC`  out  1  terminal count, combinational from `Q` and `Up`.
- `Wrap`  out  1  registered one-cycle pulse, asserted in the cycle after a wrap-around.

## Operation
- Priority on each rising edge, highest first: reset, load, count, hold.
- Reset (`Reset_n`=0): `Q` becomes `RESET_VAL` and `Wrap` becomes 0. All other inputs are ignored that cycle.
- Load (`LD_EN`=1):
  - `Q` becomes `D` if `D` < `MODULUS`, otherwise `MODULUS`-1 (clamped).
  - `Wrap` becomes 0.
  - `Cnt_EN`, `Up` and `Sat_Mode` are ignored.
- Count (`Cnt_EN`=1, `LD_EN`=0):
  - Up, `Q` < `MODULUS`-1: `Q` becomes `Q`+1.
  - Up, `Q` = `MODULUS`-1, wrap mode: `Q` becomes 0 and `Wrap` becomes 1.
  - Up, `Q` = `MODULUS`-1, saturate mode: `Q` holds and `Wrap` becomes 0.
  - Down, `Q` > 0: `Q` becomes `Q`-1.
  - Down, `Q` = 0, wrap mode: `Q` becomes `MODULUS`-1 and `Wrap` becomes 1.
  - Down, `Q` = 0, saturate mode: `Q` holds and `Wrap` becomes 0.
- Hold (`Cnt_EN`=0, `LD_EN`=0): `Q` holds and `Wrap` becomes 0.
- `TC` = (`Up` and `Q` = `MODULUS`-1) or (not `Up` and `Q` = 0). `TC` is independent of `Cnt_EN` and `Sat_Mode`.
- Arithmetic:
  - Compare against `MODULUS`-1 is at full `WIDTH`; no intermediate overflow is permitted.
  - When `MODULUS` = 2^`WIDTH`, natural binary wrap is the required result.
  - `Q` never holds a value ≥ `MODULUS` at any time.
- Direction may change on any cycle; the new `Up` value applies to that edge's update and immediately to `TC`.
- Cascading: connect the next stage's `Cnt_EN` to this stage's `Cnt_EN` AND `TC`. The next stage then advances on the same edge this stage wraps.

## Timing
- Latency is 1 cycle: inputs sampled at edge N are reflected in `Q` and `Wrap` after edge N.
- `TC` is combinational from `Q` and `Up`, with no register stage. It is valid in the same cycle as `Q`.
- `Wrap` is high for exactly one cycle per wrap event. On back-to-back wraps (e.g. `MODULUS`=2 with continuous counting), `Wrap` stays high for consecutive cycles.
- Reset mid-count takes effect at the next edge and `Wrap` clears. The first count after reset deasserts starts from `RESET_VAL`.
- Reset values: `Q` = `RESET_VAL`, `Wrap` = 0, `TC` = function of `RESET_VAL` and `Up`.
- Before the first reset edge, `Q` is unspecified; the bench does not check outputs before reset.

## Test plan
- Defaults (`WIDTH`=8, `MODULUS`=256): reset, then count up with `Sat_Mode`=0 for 256 cycles. Required: `Q` runs 0..255 and returns to 0; `TC`=1 while `Q`=255; `Wrap` is a single pulse in the cycle `Q`=0 follows 255.
- `WIDTH`=4, `MODULUS`=10: load `D`=12. Required: `Q`=9 (clamped) and `TC`=1 with `Up`=1. Then 1 up-count with wrap mode gives `Q`=0 and `Wrap`=1.
- `WIDTH`=4, `MODULUS`=10, `Sat_Mode`=1: load 8, then 3 up-counts. Required: `Q` sequence 9, 9, 9 and `Wrap` stays 0. Then `Up`=0 with 10 counts gives `Q` = 8..0, then 0 held.
- Down wrap, `MODULUS`=10: load 1, `Up`=0, wrap mode, 2 counts. Required: `Q` = 0 then 9; `Wrap` pulses with `Q`=9; `TC`=1 while `Q`=0.
- Priority: drive `Reset_n`=0 with `LD_EN`=1 and `Cnt_EN`=1 (`RESET_VAL`=3). Required: `Q`=3. Then `LD_EN`=1, `Cnt_EN`=1, `D`=5 gives `Q`=5 (load wins, no increment).
- Reset mid-operation: at `Q`=7, counting, assert `Reset_n`=0 for 1 cycle. Required: `Q`=`RESET_VAL` the next cycle and `Wrap`=0; counting resumes from `RESET_VAL` after release.
